// File: rtl/requant_pkg.sv
// Shared constants and wide-arithmetic helpers for the complex requantiser.
package requant_pkg;

  localparam int SAT_CNT_W = 16;
  localparam int CALC_W    = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t round_shift(input calc_t value, input int shift);
    calc_t half;
    half = 64'sd1 <<< (shift - 1);
    return (value + half) >>> shift;
  endfunction

  function automatic calc_t sat_clip(input calc_t value, input int wl);
    calc_t hi;
    calc_t lo;
    hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wl - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One component's datapath: rounding (feeds S1) and clipping (feeds S2).
// CONVERGENT_ROUND_EN selects round-half-to-even instead of half-up.
module requant_lane
  import requant_pkg::*;
#(
  parameter int WL_IN      = 28,
  parameter int WL_OUT     = 14,
  parameter int FRAC_SHIFT = 13,
  parameter int RND_W      = WL_IN + 1 - FRAC_SHIFT
) (
  input  logic signed [WL_IN-1:0]  raw_i,
  output logic signed [RND_W-1:0]  rnd_o,
  input  logic signed [RND_W-1:0]  rnd_i,
  output logic signed [WL_OUT-1:0] clip_o,
  output logic                     sat_o
);

  logic signed [RND_W-1:0] half_up_s;
  calc_t                   wide_s;
  calc_t                   clipped_s;

  assign half_up_s = RND_W'(round_shift(calc_t'(raw_i), FRAC_SHIFT));

`ifdef CONVERGENT_ROUND_EN
  localparam logic [FRAC_SHIFT-1:0] TIE_PAT = FRAC_SHIFT'(1'b1) << (FRAC_SHIFT - 1);
  logic tie_s;

  // On an exact tie half-up lands one above floor; clearing the LSB picks the even neighbour.
  assign tie_s = (raw_i[FRAC_SHIFT-1:0] == TIE_PAT);
  assign rnd_o = tie_s ? {half_up_s[RND_W-1:1], 1'b0} : half_up_s;
`else
  assign rnd_o = half_up_s;
`endif

  assign wide_s    = calc_t'(rnd_i);
  assign clipped_s = sat_clip(wide_s, WL_OUT);
  assign clip_o    = WL_OUT'(clipped_s);
  assign sat_o     = (clipped_s != wide_s);

endmodule

// File: rtl/complex_requant_pipe.sv
// Two-stage elastic requantiser (S1 round, S2 saturate) with frame index and saturation statistics.
// Build option: CONVERGENT_ROUND_EN (round-half-to-even in S1).
module complex_requant_pipe
  import requant_pkg::*;
#(
  parameter int WL_IN      = 28,
  parameter int WL_OUT     = 14,
  parameter int FRAC_SHIFT = 13,
  parameter int FRAME_LEN  = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WL_IN-1:0]     in_cr,
  input  logic signed [WL_IN-1:0]     in_ci,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WL_OUT-1:0]    out_cr,
  output logic signed [WL_OUT-1:0]    out_ci,
  output logic                        out_last,
  output logic                        out_sat,
  input  logic                        sat_clr,
  output logic [SAT_CNT_W-1:0]        sat_count
);

  localparam int RND_W = WL_IN + 1 - FRAC_SHIFT;
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [SAT_CNT_W-1:0] SAT_MAX  = {SAT_CNT_W{1'b1}};

  typedef struct packed {
    logic signed [WL_OUT-1:0] re;
    logic signed [WL_OUT-1:0] im;
    logic                     last;
    logic                     sat;
  } payload_t;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [RND_W-1:0] s1_cr_q, s1_cr_d, s1_ci_q, s1_ci_d;
  logic                    s1_last_q, s1_last_d;
  logic                    s2_valid_q, s2_valid_d;
  payload_t                s2_q, s2_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SAT_CNT_W-1:0]    sat_cnt_q, sat_cnt_d;

  logic                     s2_adv_s, s1_adv_s, in_fire_s, out_fire_s;
  logic signed [RND_W-1:0]  rnd_cr_s, rnd_ci_s;
  logic signed [WL_OUT-1:0] clip_cr_s, clip_ci_s;
  logic                     sat_cr_s, sat_ci_s;

  requant_lane #(.WL_IN(WL_IN), .WL_OUT(WL_OUT), .FRAC_SHIFT(FRAC_SHIFT), .RND_W(RND_W)) u_lane_cr (
    .raw_i(in_cr), .rnd_o(rnd_cr_s), .rnd_i(s1_cr_q), .clip_o(clip_cr_s), .sat_o(sat_cr_s)
  );

  requant_lane #(.WL_IN(WL_IN), .WL_OUT(WL_OUT), .FRAC_SHIFT(FRAC_SHIFT), .RND_W(RND_W)) u_lane_ci (
    .raw_i(in_ci), .rnd_o(rnd_ci_s), .rnd_i(s1_ci_q), .clip_o(clip_ci_s), .sat_o(sat_ci_s)
  );

  // A stage may load when empty or when its content leaves this same cycle.
  assign s2_adv_s   = !s2_valid_q || out_ready;
  assign s1_adv_s   = !s1_valid_q || s2_adv_s;
  assign in_fire_s  = in_valid && s1_adv_s;
  assign out_fire_s = s2_valid_q && out_ready;

  // Next-state for both stages, frame index and saturation counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cr_d    = s1_cr_q;
    s1_ci_d    = s1_ci_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    idx_d      = idx_q;
    sat_cnt_d  = sat_cnt_q;

    if (s1_adv_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (in_fire_s) begin
      s1_cr_d   = rnd_cr_s;
      s1_ci_d   = rnd_ci_s;
      s1_last_d = (idx_q == IDX_LAST);
      idx_d     = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1'b1);
    end else begin
      idx_d = idx_q;
    end

    if (s2_adv_s && s1_valid_q) begin
      s2_valid_d = 1'b1;
      s2_d.re    = clip_cr_s;
      s2_d.im    = clip_ci_s;
      s2_d.last  = s1_last_q;
      s2_d.sat   = sat_cr_s || sat_ci_s;
    end else if (s2_adv_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (sat_clr) begin
      sat_cnt_d = {SAT_CNT_W{1'b0}};
    end else if (out_fire_s && s2_q.sat && (sat_cnt_q != SAT_MAX)) begin
      sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1'b1);
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cr_q    <= {RND_W{1'b0}};
      s1_ci_q    <= {RND_W{1'b0}};
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_q       <= '{re: {WL_OUT{1'b0}}, im: {WL_OUT{1'b0}}, last: 1'b0, sat: 1'b0};
      idx_q      <= {IDX_W{1'b0}};
      sat_cnt_q  <= {SAT_CNT_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cr_q    <= s1_cr_d;
      s1_ci_q    <= s1_ci_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
      idx_q      <= idx_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_q;
  assign out_cr    = s2_q.re;
  assign out_ci    = s2_q.im;
  assign out_last  = s2_q.last;
  assign out_sat   = s2_q.sat;
  assign sat_count = sat_cnt_q;

endmodule
